line_raster_engine: RTL and testbench

LINE_RASTER_ENGINE -- requirements
Module: line_raster_engine

---
 rtl/line_raster_engine_if.sv | 27 ++
 rtl/line_raster_engine.sv | 182 ++++++++++++++++++
 tb/tb_line_raster_engine.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_raster_engine_if.sv
// rtl/line_raster_engine_if.sv - command and pixel handshake bundle for line_raster_engine
// master: drives commands, takes pixels. slave: the engine.
interface line_raster_engine_if #(
    parameter int COORD_W = 12
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_x1;
    logic [COORD_W-1:0] cmd_y1;
    logic               pix_valid;
    logic               pix_ready;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_last;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, pix_ready,
        input  cmd_ready, pix_valid, pix_x, pix_y, pix_last
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, pix_ready,
        output cmd_ready, pix_valid, pix_x, pix_y, pix_last
    );
endinterface

// File: rtl/line_raster_engine.sv
// rtl/line_raster_engine.sv - Bresenham line rasteriser emitting one pixel per handshake
// Ports: vga_clk (clock), rst (sync, active high), bus (slave: cmd_* in, pix_* out),
// line_done (pulse after the endpoint retires), busy (not IDLE).
// Optional macro LINE_RASTER_CLIP_EN: pixels outside H_RES x V_RES are stepped but not emitted.
module line_raster_engine #(
    parameter int COORD_W = 12,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic                vga_clk,
    input  logic                rst,
    line_raster_engine_if.slave bus,
    output logic                line_done,
    output logic                busy
);
    localparam int EW = COORD_W + 2;
    localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                 pend_q, pend_d, end_q, end_d;
    logic                 pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
    logic                 line_done_q, line_done_d;

    logic signed [EW:0]   e2, dx_w, dy_w;
    logic signed [EW-1:0] step_err;
    logic [COORD_W-1:0]   step_x, step_y, ld_x, ld_y, adx, ady;
    logic                 ld_end, ld_vis, in_win, retire;

    // One Bresenham step from the current point (cx_q, cy_q).
    always_comb begin
        e2       = {err_q, 1'b0};
        dx_w     = {dx_q[EW-1], dx_q};
        dy_w     = {dy_q[EW-1], dy_q};
        step_err = err_q;
        step_x   = cx_q;
        step_y   = cy_q;
        if (e2 >= dy_w) begin
            step_err = step_err + dy_q;
            step_x   = sx_neg_q ? cx_q - ONE : cx_q + ONE;
        end
        if (e2 <= dx_w) begin
            step_err = step_err + dx_q;
            step_y   = sy_neg_q ? cy_q - ONE : cy_q + ONE;
        end
    end

    assign adx = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
    assign ady = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;

    // A pending point that is not shown retires without waiting for the consumer.
    assign retire = pend_q && (bus.pix_ready || !pix_valid_q);

    // First RUN cycle presents the start point; later loads present the stepped point.
    assign ld_x   = pend_q ? step_x : cx_q;
    assign ld_y   = pend_q ? step_y : cy_q;
    assign ld_end = (ld_x == x1_q) && (ld_y == y1_q);
    assign in_win = ({{(32-COORD_W){1'b0}}, ld_x} < $unsigned(H_RES)) &&
                    ({{(32-COORD_W){1'b0}}, ld_y} < $unsigned(V_RES));
`ifdef LINE_RASTER_CLIP_EN
    assign ld_vis = in_win;
`else
    assign ld_vis = 1'b1 | in_win;  // window has no effect without clipping
`endif

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        pend_d      = pend_q;
        end_d       = end_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        line_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    x0_d    = bus.cmd_x0;
                    y0_d    = bus.cmd_y0;
                    x1_d    = bus.cmd_x1;
                    y1_d    = bus.cmd_y1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d     = $signed({2'b00, adx});
                dy_d     = -$signed({2'b00, ady});
                err_d    = $signed({2'b00, adx}) - $signed({2'b00, ady});
                sx_neg_d = x1_q < x0_q;
                sy_neg_d = y1_q < y0_q;
                cx_d     = x0_q;
                cy_d     = y0_q;
                pend_d   = 1'b0;
                state_d  = RUN;
            end
            RUN: begin
                if (!pend_q || retire) begin
                    if (pend_q && end_q) begin
                        pend_d      = 1'b0;
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        line_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        if (pend_q) begin
                            cx_d  = step_x;
                            cy_d  = step_y;
                            err_d = step_err;
                        end
                        pend_d      = 1'b1;
                        end_d       = ld_end;
                        pix_valid_d = ld_vis;
                        pix_last_d  = ld_end && ld_vis;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            pend_q      <= 1'b0;
            end_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            pend_q      <= pend_d;
            end_q       <= end_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            line_done_q <= line_done_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_x     = cx_q;
    assign bus.pix_y     = cy_q;
    assign bus.pix_last  = pix_last_q;
    assign line_done     = line_done_q;
endmodule

// File: tb/tb_line_raster_engine.sv
// tb/tb_line_raster_engine.sv - self-checking bench for line_raster_engine
module tb_line_raster_engine;
    localparam int W     = 12;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    logic vga_clk = 1'b0;
    logic rst     = 1'b1;
    logic line_done, busy;

    line_raster_engine_if #(.COORD_W(W)) bus ();

    line_raster_engine #(.COORD_W(W), .H_RES(H_RES), .V_RES(V_RES)) dut (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .bus       (bus),
        .line_done (line_done),
        .busy      (busy)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         last;
    } pix_t;

    typedef struct {
        int x0; int y0; int x1; int y1; int mode; int npix;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    pix_t exp_q[$];
    pix_t got_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    function automatic bit visible(input int x, input int y);
`ifdef LINE_RASTER_CLIP_EN
        return (x < H_RES) && (y < V_RES);
`else
        return (x >= 0) && (y >= 0);
`endif
    endfunction

    // Pixel i along the major axis; the minor coordinate is i*minor/major rounded
    // to nearest with halves rounded away from the start point.
    task automatic build_model(input int x0, input int y0, input int x1, input int y1);
        int adx, ady, n, sx, sy, a, b, x, y;
        pix_t p;
        exp_q.delete();
        adx = (x1 >= x0) ? x1 - x0 : x0 - x1;
        ady = (y1 >= y0) ? y1 - y0 : y0 - y1;
        sx  = (x1 >= x0) ? 1 : -1;
        sy  = (y1 >= y0) ? 1 : -1;
        n   = (adx >= ady) ? adx : ady;
        for (int i = 0; i <= n; i++) begin
            if (n == 0) begin
                a = 0; b = 0;
            end else if (adx >= ady) begin
                a = i; b = (2 * i * ady + adx) / (2 * adx);
            end else begin
                b = i; a = (2 * i * adx + ady) / (2 * ady);
            end
            x = x0 + sx * a;
            y = y0 + sy * b;
            if (visible(x, y)) begin
                p.x    = W'(x);
                p.y    = W'(y);
                p.last = (i == n);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int mode, input string tag);
        bit   seen_done, stall_prev, hs_last_prev, rdy;
        int   first_v, nmis;
        pix_t held, cur;
        build_model(x0, y0, x1, y1);
        check({tag, " cmd_ready"}, int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_x0 = W'(x0); bus.cmd_y0 = W'(y0);
        bus.cmd_x1 = W'(x1); bus.cmd_y1 = W'(y1);
        tick();
        got_q.delete();
        seen_done = 0; stall_prev = 0; hs_last_prev = 0; first_v = -1;
        held = '0;
        for (int cyc = 0; cyc < 20000 && !seen_done; cyc++) begin
            // Commands offered while busy must be ignored.
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_x0 = W'($urandom); bus.cmd_y0 = W'($urandom);
            bus.cmd_x1 = W'($urandom); bus.cmd_y1 = W'($urandom);
            cur.x = bus.pix_x; cur.y = bus.pix_y; cur.last = bus.pix_last;
            if (line_done) begin
                seen_done = 1;
                if (visible(x1, y1)) check({tag, " done_after_last"}, int'(hs_last_prev), 1);
                check({tag, " cmd_ready_at_done"}, int'(bus.cmd_ready), 1);
                check({tag, " busy_at_done"}, int'(busy), 0);
                check({tag, " valid_at_done"}, int'(bus.pix_valid), 0);
            end else begin
                if (stall_prev)
                    check({tag, " stall_hold"}, int'(bus.pix_valid && (cur == held)), 1);
                if (bus.pix_valid && first_v < 0) first_v = cyc;
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus.pix_ready = rdy;
                hs_last_prev  = bus.pix_valid && rdy && bus.pix_last;
                if (bus.pix_valid && rdy) got_q.push_back(cur);
                stall_prev = bus.pix_valid && !rdy;
                held       = cur;
                tick();
            end
        end
        bus.cmd_valid = 1'b0;
        bus.pix_ready = 1'b0;
        check({tag, " line_done_seen"}, int'(seen_done), 1);
        check({tag, " pixel_count"}, got_q.size(), exp_q.size());
        nmis = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= got_q.size() || got_q[k] != exp_q[k]) nmis++;
        check({tag, " pixel_mismatches"}, nmis, 0);
        if (visible(x0, y0)) check({tag, " first_valid_cycle"}, first_v, 2);
    endtask

    initial begin
        int e1x[8] = '{2, 3, 4, 5, 6, 7, 8, 9};
        int e1y[8] = '{7, 6, 6, 5, 4, 3, 3, 2};
        int nbad, nhs, rx0, ry0, rx1, ry1, lim;
        bit found;

        bus.cmd_valid = 1'b0; bus.pix_ready = 1'b0;
        bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
        rst = 1'b1;
        tick(); tick();
        check("reset pix_valid", int'(bus.pix_valid), 0);
        check("reset pix_last", int'(bus.pix_last), 0);
        check("reset line_done", int'(line_done), 0);
        check("reset busy", int'(busy), 0);
        check("reset pix_x", int'(bus.pix_x), 0);
        check("reset pix_y", int'(bus.pix_y), 0);
        rst = 1'b0;
        tick();
        check("post-reset cmd_ready", int'(bus.cmd_ready), 1);

        vecs.push_back(vec_t'{2, 7, 9, 2, 0, 8});
        vecs.push_back(vec_t'{5, 9, 3, 1, 0, 9});
        vecs.push_back(vec_t'{4, 4, 4, 4, 0, 1});
        vecs.push_back(vec_t'{0, 0, 10, 0, 1, 11});
        vecs.push_back(vec_t'{0, 0, 0, 6, 0, 7});
        vecs.push_back(vec_t'{10, 10, 3, 3, 2, 8});
        vecs.push_back(vec_t'{3, 10, 10, 3, 0, 8});
        vecs.push_back(vec_t'{12, 5, 1, 7, 2, 12});
        vecs.push_back(vec_t'{4095, 4095, 0, 0, 0, 4096});
        vecs.push_back(vec_t'{0, 4095, 4095, 100, 0, 4096});

        for (int i = 0; i < vecs.size(); i++) begin
            run_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].mode,
                     $sformatf("vec%0d", i));
`ifndef LINE_RASTER_CLIP_EN
            check($sformatf("vec%0d npix", i), got_q.size(), vecs[i].npix);
`endif
            if (i == 0) begin
                nbad = 0;
                for (int k = 0; k < 8; k++)
                    if (k >= got_q.size() || int'(got_q[k].x) != e1x[k] ||
                        int'(got_q[k].y) != e1y[k] || got_q[k].last != (k == 7)) nbad++;
                check("vec0 literal pixels", nbad, 0);
            end
            if (i == 1) begin
                nbad = 0;
                for (int k = 0; k < got_q.size(); k++)
                    if (int'(got_q[k].y) != 9 - k || got_q[k].x > 5 || got_q[k].x < 3 ||
                        (k > 0 && got_q[k].x > got_q[k-1].x)) nbad++;
                check("vec1 steep shape", nbad, 0);
            end
        end

        // Reset while the third pixel of (0,0)->(20,5) is on offer.
        bus.cmd_valid = 1'b1;
        bus.cmd_x0 = W'(0); bus.cmd_y0 = W'(0); bus.cmd_x1 = W'(20); bus.cmd_y1 = W'(5);
        bus.pix_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        nhs = 0; found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (bus.pix_valid && nhs == 2) found = 1;
            else begin
                if (bus.pix_valid) nhs++;
                tick();
            end
        end
        check("rst third pixel reached", int'(found), 1);
        check("rst third pixel x", int'(bus.pix_x), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.pix_ready = 1'b0;
        check("rst mid pix_valid", int'(bus.pix_valid), 0);
        check("rst mid busy", int'(busy), 0);
        check("rst mid line_done", int'(line_done), 0);
        check("rst mid pix_x", int'(bus.pix_x), 0);
        nbad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (line_done || busy) nbad++;
        end
        check("rst no line_done", nbad, 0);
        run_line(3, 2, 8, 9, 0, "post_rst");

`ifdef LINE_RASTER_CLIP_EN
        run_line(636, 0, 643, 0, 0, "clip");
        check("clip emitted", got_q.size(), 4);
        nbad = 0;
        for (int k = 0; k < got_q.size(); k++)
            if (int'(got_q[k].x) != 636 + k || got_q[k].last) nbad++;
        check("clip pixels", nbad, 0);
`endif

        for (int r = 0; r < 30; r++) begin
            lim = (r < 3) ? 4095 : 40;
            rx0 = $urandom_range(0, lim); ry0 = $urandom_range(0, lim);
            rx1 = $urandom_range(0, lim); ry1 = $urandom_range(0, lim);
            if (r == 5) begin rx1 = rx0; ry1 = ry0; end
            run_line(rx0, ry0, rx1, ry1, 2, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
